// File: rtl/gdp_max_pkg.sv
// -----------------------------------------------------------------------------
// gdp_max_pkg
// Definitions shared by the Gaussian scoring stages:
//   num              - 16-bit signed fixed-point score, DECIMAL_POSITION
//                      fractional bits. The upstream Gaussian stage and
//                      gdp_max both import this type.
//   DECIMAL_POSITION - number of fractional bits in num.
//   acc_state_e      - state encoding of the gdp_max frame accumulator.
//   num_gt           - signed strict greater-than on two num values.
// -----------------------------------------------------------------------------
package gdp_max_pkg;

    localparam int NUM_W            = 16;
    localparam int DECIMAL_POSITION = 11;

    typedef logic signed [NUM_W-1:0] num;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

    // Strict comparison: an equal score must not replace the stored one,
    // so that ties keep the earlier index.
    function automatic logic num_gt(input num a, input num b);
        return (a > b);
    endfunction

endpackage

// File: rtl/gdp_max_if.sv
// -----------------------------------------------------------------------------
// gdp_max_if
// Bundles the score stream coming in and the frame result going out of
// gdp_max.
//   Inputs to gdp_max : data_ready, ln_p, frame_start, frame_end, score_ack
//   Outputs of gdp_max: best_score, best_index, score_valid, overflow, seq_err
// Modports:
//   slave  - gdp_max side
//   master - producer/consumer side (upstream stage, result consumer, bench)
//
// Handshake: the incoming stream has no backpressure; every cycle with
// data_ready=1 carries one ln_p, and frame_start/frame_end only mean anything
// on such cycles. A result is transferred on a cycle where
// score_valid && score_ack; while score_valid=1 the result fields are stable.
// -----------------------------------------------------------------------------
interface gdp_max_if
    import gdp_max_pkg::*;
#(
    parameter int IDX_W = 6
);

    logic             data_ready;
    num               ln_p;
    logic             frame_start;
    logic             frame_end;
    num               best_score;
    logic [IDX_W-1:0] best_index;
    logic             score_valid;
    logic             score_ack;
    logic             overflow;
    logic             seq_err;

    modport slave (
        input  data_ready,
        input  ln_p,
        input  frame_start,
        input  frame_end,
        input  score_ack,
        output best_score,
        output best_index,
        output score_valid,
        output overflow,
        output seq_err
    );

    modport master (
        output data_ready,
        output ln_p,
        output frame_start,
        output frame_end,
        output score_ack,
        input  best_score,
        input  best_index,
        input  score_valid,
        input  overflow,
        input  seq_err
    );

endinterface

// File: rtl/gdp_max.sv
// -----------------------------------------------------------------------------
// gdp_max
// Finds the largest Gaussian log-probability of each frame and the 0-based
// arrival position of that score within the frame.
//
// Parameters:
//   MAX_GAUSS - maximum number of scores per frame
//   IDX_W     - index width, 2**IDX_W >= MAX_GAUSS; must equal the IDX_W of
//               the connected gdp_max_if
// Ports:
//   clk       - clock, rising edge
//   nreset    - asynchronous active-low reset (release synchronised outside)
//   bus       - gdp_max_if.slave: score stream in, frame result out
//   dbg_state - current accumulator FSM state
//
// Structure: a two-state accumulator (IDLE/ACCUM) builds the running maximum
// of the current frame; a separate output register holds the last completed
// result, so a new frame can be accumulated while the previous result waits
// for its consumer. A result that completes while the output register is
// still occupied and not being acknowledged is dropped and flagged.
// -----------------------------------------------------------------------------
module gdp_max
    import gdp_max_pkg::*;
#(
    parameter int MAX_GAUSS = 64,
    parameter int IDX_W     = 6
) (
    input  logic        clk,
    input  logic        nreset,
    gdp_max_if.slave    bus,
    output acc_state_e  dbg_state
);

    // count must be able to hold MAX_GAUSS itself, hence one extra bit.
    localparam int                 CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_GAUSS);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(MAX_GAUSS - 1);

    // Accumulator state
    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    num               acc_best_q, acc_best_d;
    logic [IDX_W-1:0] acc_idx_q, acc_idx_d;

    // Completion strobe and the result it carries
    logic             done;
    num               done_score;
    logic [IDX_W-1:0] done_idx;
    logic             seq_set;

    // Output register
    num               best_score_q;
    logic [IDX_W-1:0] best_index_q;
    logic             score_valid_q;
    logic             overflow_q;
    logic             seq_err_q;

    // -------------------------------------------------------------------------
    // Accumulator FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            acc_best_q <= '0;
            acc_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_best_q <= acc_best_d;
            acc_idx_q  <= acc_idx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Accumulator FSM: next state and compare/update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_best_d = acc_best_q;
        acc_idx_d  = acc_idx_q;
        done       = 1'b0;
        done_score = acc_best_q;
        done_idx   = acc_idx_q;
        seq_set    = 1'b0;

        if (bus.data_ready) begin
            if (bus.frame_start) begin
                // A start always opens a fresh frame; inside a frame it is a
                // protocol error and the partial frame is thrown away.
                if (state_q == ST_ACCUM) begin
                    seq_set = 1'b1;
                end
                acc_best_d = bus.ln_p;
                acc_idx_d  = '0;
                count_d    = CNT_W'(1);
                if (bus.frame_end) begin
                    done       = 1'b1;
                    done_score = bus.ln_p;
                    done_idx   = '0;
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_ACCUM;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        // Data outside a frame is dropped.
                        seq_set = 1'b1;
                    end
                    ST_ACCUM: begin
                        if (count_q == CNT_MAX) begin
                            // Frame is full: extra samples are discarded,
                            // but the closing sample still competes. Its
                            // position does not fit the index, so it is
                            // reported in the last slot.
                            if (bus.frame_end) begin
                                done    = 1'b1;
                                state_d = ST_IDLE;
                                if (num_gt(bus.ln_p, acc_best_q)) begin
                                    done_score = bus.ln_p;
                                    done_idx   = IDX_LAST;
                                end
                            end else begin
                                seq_set = 1'b1;
                            end
                        end else begin
                            if (num_gt(bus.ln_p, acc_best_q)) begin
                                acc_best_d = bus.ln_p;
                                acc_idx_d  = count_q[IDX_W-1:0];
                            end
                            count_d = count_q + CNT_W'(1);
                            if (bus.frame_end) begin
                                done       = 1'b1;
                                done_score = acc_best_d;
                                done_idx   = acc_idx_d;
                                state_d    = ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register and sticky flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            best_score_q  <= '0;
            best_index_q  <= '0;
            score_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            if (done) begin
                // The slot is free if empty or being drained this same edge.
                if (!score_valid_q || bus.score_ack) begin
                    best_score_q  <= done_score;
                    best_index_q  <= done_idx;
                    score_valid_q <= 1'b1;
                end else begin
                    overflow_q    <= 1'b1;
                end
            end else if (score_valid_q && bus.score_ack) begin
                score_valid_q <= 1'b0;
            end
            if (seq_set) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    assign bus.best_score  = best_score_q;
    assign bus.best_index  = best_index_q;
    assign bus.score_valid = score_valid_q;
    assign bus.overflow    = overflow_q;
    assign bus.seq_err     = seq_err_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_gdp_max.sv
// -----------------------------------------------------------------------------
// tb_gdp_max
// Bench for gdp_max. A per-cycle vector table drives the default-size
// instance (inputs plus expected outputs after the edge); a hand-written
// sequence drives a MAX_GAUSS=4 instance through the full-frame corner case.
// -----------------------------------------------------------------------------
module tb_gdp_max;
    import gdp_max_pkg::*;

    logic       clk;
    logic       nreset;
    acc_state_e dbg_state;
    acc_state_e dbg_state2;

    gdp_max_if #(.IDX_W(6)) bus  ();
    gdp_max_if #(.IDX_W(2)) bus2 ();

    gdp_max #(.MAX_GAUSS(64), .IDX_W(6)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    gdp_max #(.MAX_GAUSS(4), .IDX_W(2)) dut4 (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (bus2),
        .dbg_state (dbg_state2)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       dr;
        logic       fs;
        logic       fe;
        logic       ack;
        num         lnp;
        logic       ev;
        num         es;
        logic [5:0] ei;
        logic       eo;
        logic       ese;
    } vec_t;

    vec_t tbl[$];

    int total = 0;
    int bad   = 0;

    task automatic add(input logic rst, input logic dr, input logic fs,
                       input logic fe, input logic ack, input int lnp,
                       input logic ev, input int es, input int ei,
                       input logic eo, input logic ese);
        vec_t v;
        v.rst = rst; v.dr = dr; v.fs = fs; v.fe = fe; v.ack = ack;
        v.lnp = num'(lnp);
        v.ev = ev; v.es = num'(es); v.ei = 6'(ei); v.eo = eo; v.ese = ese;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int i);
        @(negedge clk);
        nreset          = !v.rst;
        bus.data_ready  = v.dr;
        bus.frame_start = v.fs;
        bus.frame_end   = v.fe;
        bus.score_ack   = v.ack;
        bus.ln_p        = v.lnp;
        if (v.rst) begin
            #1;
            chk($sformatf("v%0d async_valid", i), 16'(bus.score_valid), 16'd0);
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d score_valid", i), 16'(bus.score_valid), 16'(v.ev));
        chk($sformatf("v%0d best_score", i), bus.best_score, v.es);
        chk($sformatf("v%0d best_index", i), 16'(bus.best_index), 16'(v.ei));
        chk($sformatf("v%0d overflow", i), 16'(bus.overflow), 16'(v.eo));
        chk($sformatf("v%0d seq_err", i), 16'(bus.seq_err), 16'(v.ese));
    endtask

    // Drive one cycle on the MAX_GAUSS=4 instance.
    task automatic drive4(input logic dr, input logic fs, input logic fe,
                          input int lnp);
        @(negedge clk);
        bus2.data_ready  = dr;
        bus2.frame_start = fs;
        bus2.frame_end   = fe;
        bus2.ln_p        = num'(lnp);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nreset           = 1'b0;
        bus.data_ready   = 1'b0;
        bus.frame_start  = 1'b0;
        bus.frame_end    = 1'b0;
        bus.score_ack    = 1'b0;
        bus.ln_p         = '0;
        bus2.data_ready  = 1'b0;
        bus2.frame_start = 1'b0;
        bus2.frame_end   = 1'b0;
        bus2.score_ack   = 1'b1;
        bus2.ln_p        = '0;

        //   rst dr fs fe ack  lnp      ev  es      ei eo se
        add(1, 0, 0, 0, 0,      0,      0,      0, 0, 0, 0); // reset state
        // frame {-100,50,20,50}, ack high
        add(0, 1, 1, 0, 1,   -100,      0,      0, 0, 0, 0);
        add(0, 1, 0, 0, 1,     50,      0,      0, 0, 0, 0);
        add(0, 1, 0, 0, 1,     20,      0,      0, 0, 0, 0);
        add(0, 1, 0, 1, 1,     50,      1,     50, 1, 0, 0);
        add(0, 0, 0, 0, 1,      0,      0,     50, 1, 0, 0);
        // single-score frame at the most negative value
        add(0, 1, 1, 1, 0, -32768,      1, -32768, 0, 0, 0);
        add(0, 0, 0, 0, 0,      0,      1, -32768, 0, 0, 0);
        add(0, 0, 0, 0, 1,      0,      0, -32768, 0, 0, 0);
        add(0, 0, 0, 0, 1,      0,      0, -32768, 0, 0, 0); // ack while empty
        add(0, 1, 0, 0, 0,     99,      0, -32768, 0, 0, 1); // data in IDLE
        add(1, 0, 0, 0, 0,      0,      0,      0, 0, 0, 0);
        // back-to-back {1,2},{5,3}, no ack -> overflow
        add(0, 1, 1, 0, 0,      1,      0,      0, 0, 0, 0);
        add(0, 1, 0, 1, 0,      2,      1,      2, 1, 0, 0);
        add(0, 1, 1, 0, 0,      5,      1,      2, 1, 0, 0);
        add(0, 1, 0, 1, 0,      3,      1,      2, 1, 1, 0);
        add(0, 0, 0, 0, 0,      0,      1,      2, 1, 1, 0);
        add(0, 0, 0, 0, 1,      0,      0,      2, 1, 1, 0);
        add(1, 0, 0, 0, 0,      0,      0,      0, 0, 0, 0);
        // same frames, ack on second completion
        add(0, 1, 1, 0, 0,      1,      0,      0, 0, 0, 0);
        add(0, 1, 0, 1, 0,      2,      1,      2, 1, 0, 0);
        add(0, 1, 1, 0, 0,      5,      1,      2, 1, 0, 0);
        add(0, 1, 0, 1, 1,      3,      1,      5, 0, 0, 0);
        add(0, 0, 0, 0, 1,      0,      0,      5, 0, 0, 0);
        // negative scores with a tie: earlier index wins
        add(0, 1, 1, 0, 1,     -5,      0,      5, 0, 0, 0);
        add(0, 1, 0, 0, 1,     -3,      0,      5, 0, 0, 0);
        add(0, 1, 0, 0, 1,     -3,      0,      5, 0, 0, 0);
        add(0, 1, 0, 1, 1,     -7,      1,     -3, 1, 0, 0);
        add(0, 0, 0, 0, 1,      0,      0,     -3, 1, 0, 0);
        // bubble inside a frame
        add(0, 1, 1, 0, 0,     10,      0,     -3, 1, 0, 0);
        add(0, 0, 0, 0, 0,      0,      0,     -3, 1, 0, 0);
        add(0, 1, 0, 1, 0,     30,      1,     30, 1, 0, 0);
        // frame_start inside a frame restarts it
        add(0, 1, 1, 0, 1,     40,      0,     30, 1, 0, 0);
        add(0, 1, 0, 0, 1,     45,      0,     30, 1, 0, 0);
        add(0, 1, 1, 0, 1,      8,      0,     30, 1, 0, 1);
        add(0, 1, 0, 1, 1,      6,      1,      8, 0, 0, 1);
        // reset after three samples, then frame {7}
        add(0, 1, 1, 0, 1,     11,      0,      8, 0, 0, 1);
        add(0, 1, 0, 0, 1,     12,      0,      8, 0, 0, 1);
        add(0, 1, 0, 0, 1,     13,      0,      8, 0, 0, 1);
        add(1, 0, 0, 0, 0,      0,      0,      0, 0, 0, 0);
        add(0, 1, 1, 1, 0,      7,      1,      7, 0, 0, 0);
        add(0, 0, 0, 0, 1,      0,      0,      7, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Idle the default instance for the rest of the run.
        @(negedge clk);
        bus.data_ready = 1'b0;
        bus.score_ack  = 1'b0;

        // ---- MAX_GAUSS=4: six samples without frame_end, closed by the 7th
        drive4(1, 1, 0, 3);
        drive4(1, 0, 0, 9);
        drive4(1, 0, 0, -2);
        drive4(1, 0, 0, 4);
        chk("full4 seq_err_before", 16'(bus2.seq_err), 16'd0);
        chk("full4 state_accum", 16'(dbg_state2), 16'(ST_ACCUM));
        drive4(1, 0, 0, 100);
        chk("full4 seq_err_after", 16'(bus2.seq_err), 16'd1);
        drive4(1, 0, 0, 100);
        chk("full4 valid_early", 16'(bus2.score_valid), 16'd0);
        drive4(1, 0, 1, 5);
        chk("full4 valid", 16'(bus2.score_valid), 16'd1);
        chk("full4 score", bus2.best_score, 16'd9);
        chk("full4 index", 16'(bus2.best_index), 16'd1);
        chk("full4 state_idle", 16'(dbg_state2), 16'(ST_IDLE));
        drive4(0, 0, 0, 0);
        chk("full4 valid_clear", 16'(bus2.score_valid), 16'd0);

        // ---- exactly MAX_GAUSS samples, maximum in the last slot
        drive4(1, 1, 0, 1);
        drive4(1, 0, 0, 2);
        drive4(1, 0, 0, 3);
        drive4(1, 0, 1, 4);
        chk("exact4 valid", 16'(bus2.score_valid), 16'd1);
        chk("exact4 score", bus2.best_score, 16'd4);
        chk("exact4 index", 16'(bus2.best_index), 16'd3);
        chk("exact4 overflow", 16'(bus2.overflow), 16'd0);
        drive4(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gdp_max.md
GDP_MAX -- requirements
Module: gdp_max

Interface
REQ-001 SHALL have parameter MAX_GAUSS, default 64, meaning the maximum number of Gaussian scores per frame.
REQ-002 SHALL have parameter IDX_W, default 6, meaning the index width; it SHALL satisfy 2**IDX_W >= MAX_GAUSS.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port nreset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port data_ready, input, 1 bit: ln_p is valid this cycle (driven by the upstream Gaussian stage).
REQ-006 SHALL have port ln_p, input, num (16-bit signed, 11 fractional bits): Gaussian log-probability.
REQ-007 SHALL have port frame_start, input, 1 bit: the current ln_p is the first score of a frame; qualified by data_ready.
REQ-008 SHALL have port frame_end, input, 1 bit: the current ln_p is the last score of a frame; qualified by data_ready.
REQ-009 SHALL have port best_score, output, num: maximum ln_p of the completed frame.
REQ-010 SHALL have port best_index, output, IDX_W bits: 0-based arrival position of best_score within its frame.
REQ-011 SHALL have port score_valid, output, 1 bit: best_score and best_index are valid.
REQ-012 SHALL have port score_ack, input, 1 bit: the consumer takes the result when score_valid && score_ack.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag, a completed frame result was dropped.
REQ-014 SHALL have port seq_err, output, 1 bit: sticky flag, a framing protocol violation occurred.

Function
REQ-015 The accumulator FSM SHALL have the states IDLE and ACCUM; the output register SHALL be independent of it (double buffer).
REQ-016 In IDLE, data_ready && frame_start SHALL load acc_best=ln_p, acc_idx=0 and count=1, then go to ACCUM; if frame_end is also high, the frame SHALL complete that cycle and the FSM SHALL stay in IDLE.
REQ-017 In IDLE, data_ready without frame_start SHALL be ignored and SHALL set seq_err.
REQ-018 In ACCUM, each data_ready SHALL compare ln_p against acc_best as signed values; a strictly greater ln_p SHALL load acc_best=ln_p and acc_idx=count; count SHALL then increment.
REQ-019 Ties SHALL keep the earlier (lower) index.
REQ-020 In ACCUM, data_ready with frame_start SHALL set seq_err and restart the frame exactly as in REQ-016.
REQ-021 When count==MAX_GAUSS and data_ready arrives without frame_end, the sample SHALL be discarded, seq_err SHALL be set, and the FSM SHALL stay in ACCUM until frame_end.
REQ-022 Frame completion SHALL include the final sample (the frame_end ln_p) in the comparison; the FSM SHALL return to IDLE.
REQ-023 On completion at rising edge N, the result SHALL be loaded into the output register, with score_valid=1 visible after edge N (1-cycle latency).
REQ-024 While score_valid=1, best_score and best_index SHALL stay stable; score_valid SHALL clear on the edge where score_ack=1, unless a new result loads on that same edge.
REQ-025 On completion with score_valid=1 and score_ack=0, the new result SHALL be dropped, the old result retained, and overflow set.
REQ-026 On completion with score_valid=1 and score_ack=1 in the same cycle, the new result SHALL load and score_valid SHALL remain 1; no overflow SHALL be raised.
REQ-027 score_ack while score_valid=0 SHALL have no effect.
REQ-028 overflow and seq_err SHALL clear only on reset.

Reset
REQ-029 nreset low SHALL asynchronously force: FSM=IDLE, count=0, acc_best=0, acc_idx=0, best_score=0, best_index=0, score_valid=0, overflow=0, seq_err=0.
REQ-030 A partial frame interrupted by reset SHALL be discarded; no result SHALL be emitted for it.
REQ-031 Release of nreset SHALL be synchronised externally; the block SHALL accept data on the first edge after release.

Structure
REQ-032 The num typedef and the DECIMAL_POSITION=11 constant SHALL live in a shared package that both gdp_max and the upstream Gaussian stage import.
REQ-033 No sub-module SHALL be used; the compare/update logic SHALL be inline.

Verification
REQ-034 Frame of 4 scores {-100, 50, 20, 50} (frame_start on the first, frame_end on the last), ack held high -> best_score=50, best_index=1, score_valid for 1 cycle, appearing one cycle after frame_end.
REQ-035 Single-score frame: frame_start and frame_end together, ln_p=-32768 -> best_score=-32768, best_index=0.
REQ-036 Two back-to-back 2-score frames {1,2} and {5,3}, score_ack=0 throughout -> output holds 2/idx1; overflow=1 after the second frame_end.
REQ-037 Same two frames with score_ack=1 asserted on the cycle of the second completion -> output becomes 5/idx0, score_valid stays 1, overflow=0.
REQ-038 With MAX_GAUSS=4, six samples sent without frame_end, then frame_end on the seventh -> seq_err=1; result is the max of the first 4 samples plus the seventh.
REQ-039 Assert nreset low mid-frame after 3 samples, release, then send frame {7} -> all outputs return to 0 during reset; the only result is 7/idx0.
